ddr_rd_cmd_issuer: RTL and testbench
====================================

Name: ddr_rd_cmd_issuer

Overview:
- Sits on the consumer side of the DDR read-address prefetch FIFO.
- Pops read-request entries ({beat count, byte address}) from the FIFO's show-ahead read port and splits each entry into AXI4 INCR read bursts of at most MAX_BURST beats.
- Issues the bursts on an AR channel and throttles to MAX_OUTSTANDING bursts in flight, tracked by counting R-channel last beats.

Parameters:
ADDR_W, 28, byte address width of DDR space and of the entry address field
CNT_W, 8, entry beat-count field width
FIFO_DW, 36, FIFO entry width; must equal ADDR_W+CNT_W
BYTES_PER_BEAT, 32, DDR data bytes per beat; power of 2, 1..128
MAX_BURST, 16, max beats per AR burst; 1..256
MAX_OUTSTANDING, 4, max AR bursts without a returned rlast; 1..15

Ports:
clk  in  1  single clock; read side of the prefetch FIFO runs on it
rst  in  1  synchronous, active-high reset
fifo_rd_data  in  FIFO_DW  show-ahead entry; [FIFO_DW-1:ADDR_W]=beats, [ADDR_W-1:0]=byte addr
fifo_rd_vld  in  1  entry valid
fifo_rd_en  out  1  pop; entry consumed when fifo_rd_vld&fifo_rd_en
araddr  out  ADDR_W  burst start byte address
arlen  out  8  beats-1
arsize  out  3  constant log2(BYTES_PER_BEAT)
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  AR request valid
arready  in  1  AR accept
rvalid  in  1  R beat valid (monitored only)
rready  in  1  R beat ready (monitored only)
rlast  in  1  last beat of burst
outstanding  out  4  bursts in flight
busy  out  1  entry in progress (state != IDLE)
err_zero_len  out  1  1-cycle pulse: entry with beats==0 dropped
err_underflow  out  1  1-cycle pulse: rlast handshake while outstanding==0

Behaviour:
- Reset: state=IDLE; fifo_rd_en=0, arvalid=0, araddr=0, arlen=0, outstanding=0, busy=0, err pulses=0.
- rst has priority over every other event; reset mid-burst abandons the current entry, and no AR is held.
- States: IDLE, SPLIT, ISSUE.
- IDLE, fifo_rd_vld=1:
  - Drive fifo_rd_en=1 combinationally in this cycle.
  - Latch addr (low log2(BYTES_PER_BEAT) bits forced 0) and rem=beats.
  - beats==0: pulse err_zero_len next cycle and stay IDLE.
  - Otherwise go to SPLIT.
- fifo_rd_en is asserted only in IDLE with fifo_rd_vld=1: exactly one pop per entry, never while busy.
- SPLIT:
  - chunk=min(rem,MAX_BURST).
  - If outstanding<MAX_OUTSTANDING, or an rlast handshake is occurring this cycle: register araddr=addr, arlen=chunk-1, arvalid=1; go to ISSUE.
  - Otherwise stay in SPLIT.
- ISSUE:
  - araddr and arlen are held stable while arvalid=1 and arready=0.
  - On arvalid&arready: arvalid=0; addr=(addr+chunk*BYTES_PER_BEAT) mod 2^ADDR_W; rem-=chunk.
  - rem==0 -> IDLE, else -> SPLIT.
- Latency: entry visible in IDLE at cycle 0 -> pop at cycle 0 -> arvalid=1 at cycle 2 when credit is available. Each subsequent burst needs at least 2 cycles (SPLIT+ISSUE).
- Outstanding counter:
  - +1 on AR handshake; -1 on rvalid&rready&rlast.
  - Both in the same cycle: unchanged.
  - -1 with outstanding==0: stays 0 and pulses err_underflow.
  - Never exceeds MAX_OUTSTANDING.
- Address arithmetic wraps silently at 2^ADDR_W. The block does not split at 4KB; upstream guarantees burst alignment.
- Bursts are issued in entry order and ascending address order.

Test Plan:
- Defaults; entry beats=40, addr=0x0001000; arready=1; rlast returned after each AR -> AR sequence (0x0001000,len15), (0x0001200,len15), (0x0001400,len7); exactly one fifo_rd_en pulse; busy falls after the third handshake.
- Entry beats=100, arready=1, no rlast -> exactly 4 ARs then arvalid stays 0 with outstanding=4. One rlast -> the 5th AR follows within 2 cycles; outstanding stays 4.
- Entry beats=0 followed by beats=1 at 0x0000020 -> err_zero_len pulses once; the single AR is (0x0000020,len0); 2 pops total.
- Entry beats=20, addr=0xFFFFF00 -> ARs (0xFFFFF00,len15) and (0x0000100,len3), showing address wrap.
- arready held 0 for 5 cycles -> araddr/arlen/arvalid stable throughout. Simultaneous AR handshake and rlast at outstanding=2 -> outstanding stays 2. rlast at outstanding=0 -> err_underflow pulses and outstanding=0.
- Assert rst for 1 cycle while in ISSUE with rem>0 -> next cycle arvalid=0, outstanding=0, busy=0, state IDLE; the following entry is processed normally.

Source files
------------

// File: rtl/ddr_rd_cmd_issuer.sv
// ddr_rd_cmd_issuer
// Consumes {beats, byte address} entries from the show-ahead prefetch FIFO and
// issues them as AXI4 INCR read bursts of at most MAX_BURST beats. The number
// of bursts in flight is limited to MAX_OUTSTANDING by counting returned rlast beats.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a FIFO entry; pops it and latches address/beats
// S_SPLIT | sizing the next burst; waits here until a credit is free
// S_ISSUE | AR request presented; command held until arready
module ddr_rd_cmd_issuer #(
    parameter int ADDR_W          = 28,
    parameter int CNT_W           = 8,
    parameter int FIFO_DW         = 36,
    parameter int BYTES_PER_BEAT  = 32,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FIFO_DW-1:0] fifo_rd_data,
    input  logic               fifo_rd_vld,
    output logic               fifo_rd_en,
    output logic [ADDR_W-1:0]  araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic               rvalid,
    input  logic               rready,
    input  logic               rlast,
    output logic [3:0]         outstanding,
    output logic               busy,
    output logic               err_zero_len,
    output logic               err_underflow
);

    localparam int BSH = $clog2(BYTES_PER_BEAT);
    // chunk width must hold MAX_BURST (up to 256) as well as any beat count
    localparam int CHW = (CNT_W > 9) ? CNT_W : 9;
    localparam logic [CHW-1:0]    MAXB  = CHW'(MAX_BURST);
    localparam logic [3:0]        MAXO  = 4'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] AMASK = ~(ADDR_W'(BYTES_PER_BEAT - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SPLIT = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_rem;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic              r_arvalid;
    logic [3:0]        r_out;
    logic              r_err_zero;
    logic              r_err_uf;

    logic [CNT_W-1:0]  w_beats;
    logic [ADDR_W-1:0] w_entry_addr;
    logic [CHW-1:0]    w_rem_ext;
    logic [CHW-1:0]    w_chunk;
    logic [7:0]        w_arlen;
    logic [ADDR_W-1:0] w_step;
    logic [CNT_W-1:0]  w_rem_next;
    logic              w_ar_hs;
    logic              w_rlast_hs;

    assign w_beats      = fifo_rd_data[FIFO_DW-1:ADDR_W];
    assign w_entry_addr = fifo_rd_data[ADDR_W-1:0];
    assign w_rem_ext    = CHW'(r_rem);
    assign w_chunk      = (w_rem_ext < MAXB) ? w_rem_ext : MAXB;
    assign w_arlen      = 8'(w_chunk - CHW'(1));
    assign w_step       = ADDR_W'(w_chunk) << BSH;
    assign w_rem_next   = r_rem - CNT_W'(w_chunk);
    assign w_ar_hs      = r_arvalid & arready;
    assign w_rlast_hs   = rvalid & rready & rlast;

    // pop is combinational so the entry is consumed in the cycle it is seen
    assign fifo_rd_en    = ~rst & (r_state == S_IDLE) & fifo_rd_vld;
    assign araddr        = r_araddr;
    assign arlen         = r_arlen;
    assign arsize        = 3'(BSH);
    assign arburst       = 2'b01;
    assign arvalid       = r_arvalid;
    assign outstanding   = r_out;
    assign busy          = (r_state != S_IDLE);
    assign err_zero_len  = r_err_zero;
    assign err_underflow = r_err_uf;

    // entry splitting FSM with registered AR command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arvalid  <= 1'b0;
            r_err_zero <= 1'b0;
        end else begin
            r_err_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fifo_rd_vld) begin
                        r_addr <= w_entry_addr & AMASK;
                        r_rem  <= w_beats;
                        if (w_beats == '0) begin
                            r_err_zero <= 1'b1;
                        end else begin
                            r_state <= S_SPLIT;
                        end
                    end
                end
                S_SPLIT: begin
                    // a returning rlast this cycle frees a credit in time
                    if ((r_out < MAXO) || w_rlast_hs) begin
                        r_araddr  <= r_addr;
                        r_arlen   <= w_arlen;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_addr    <= r_addr + w_step;
                        r_rem     <= w_rem_next;
                        r_state   <= (w_rem_next == '0) ? S_IDLE : S_SPLIT;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // bursts-in-flight counter, saturating at zero with an underflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_err_uf <= 1'b0;
        end else begin
            r_err_uf <= 1'b0;
            if (w_ar_hs && !w_rlast_hs) begin
                r_out <= r_out + 4'd1;
            end else if (w_rlast_hs && !w_ar_hs) begin
                if (r_out == '0) begin
                    r_err_uf <= 1'b1;
                end else begin
                    r_out <= r_out - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_rd_cmd_issuer.sv
// Bench for ddr_rd_cmd_issuer: directed scenarios plus randomized traffic,
// checked against a queue-based model of the expected AR burst stream.
module tb_ddr_rd_cmd_issuer;

    localparam int ADDR_W  = 28;
    localparam int CNT_W   = 8;
    localparam int FIFO_DW = 36;
    localparam int BPB     = 32;
    localparam int MAXB    = 16;
    localparam int MAXO    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [FIFO_DW-1:0] fifo_rd_data;
    logic               fifo_rd_vld;
    logic               fifo_rd_en;
    logic [ADDR_W-1:0]  araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready;
    logic               rvalid;
    logic               rready;
    logic               rlast;
    logic [3:0]         outstanding;
    logic               busy;
    logic               err_zero_len;
    logic               err_underflow;

    ddr_rd_cmd_issuer #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DW(FIFO_DW),
        .BYTES_PER_BEAT(BPB), .MAX_BURST(MAXB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .outstanding(outstanding), .busy(busy),
        .err_zero_len(err_zero_len), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        l;
    } ar_t;

    int errors = 0;
    int checks = 0;

    logic [FIFO_DW-1:0] fq[$];     // FIFO contents visible to the DUT
    ar_t                arq[$];    // bursts expected but not yet accepted
    ar_t                arlog[$];  // every accepted burst, in order
    int                 hs_cyc[$]; // cycle of each accepted burst

    int  cyc = 0;
    int  exp_out = 0;
    bit  exp_zero, exp_uf;
    int  pops_n = 0, zero_n = 0;
    int  last_pop_cyc = 0, last_rl_cyc = 0;
    bit  rst_req, ar_rand, ar_fix, force_rl;
    int  r_mode;                   // 0 none, 1 rlast per pending burst, 2 random
    bit  held = 1'b0;
    logic [ADDR_W-1:0] h_addr;
    logic [7:0]        h_len;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_entry(input int beats, input logic [ADDR_W-1:0] a);
        fq.push_back({8'(beats), a});
    endtask

    // expected bursts of one entry, straight from the splitting rule
    task automatic split_entry(input logic [FIFO_DW-1:0] e);
        int rem = int'(e[FIFO_DW-1:ADDR_W]);
        logic [ADDR_W-1:0] a = e[ADDR_W-1:0] & ~(ADDR_W'(BPB - 1));
        int c;
        if (rem == 0) exp_zero = 1'b1;
        while (rem > 0) begin
            c = (rem < MAXB) ? rem : MAXB;
            arq.push_back({a, 8'(c - 1)});
            a = a + ADDR_W'(c * BPB);
            rem -= c;
        end
    endtask

    // one clock: drive inputs, predict the edge, check the registered results
    task automatic tick();
        bit pop, hs, rl, rsend, busy_exp;
        logic [FIFO_DW-1:0] e;
        ar_t x;
        rst          = rst_req;
        fifo_rd_vld  = (fq.size() > 0);
        fifo_rd_data = (fq.size() > 0) ? fq[0] : '0;
        arready      = ar_rand ? ($urandom_range(0, 2) != 0) : ar_fix;
        rsend = force_rl || (r_mode == 1 && exp_out > 0) ||
                (r_mode == 2 && exp_out > 0 && $urandom_range(0, 2) == 0);
        if (rsend) begin
            rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        end else begin
            rvalid = 1'($urandom_range(0, 1));
            rready = 1'($urandom_range(0, 1));
            rlast  = (rvalid && rready) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        #1;
        pop = fifo_rd_vld && fifo_rd_en;
        hs  = arvalid && arready;
        rl  = rvalid && rready && rlast;
        check("rd_en", fifo_rd_en, !rst && fifo_rd_vld && arq.size() == 0);
        if (held) begin
            check("hold_arvalid", arvalid, 1);
            check("hold_araddr", araddr, h_addr);
            check("hold_arlen", arlen, h_len);
        end
        held   = !rst && arvalid && !arready;
        h_addr = araddr;
        h_len  = arlen;
        exp_zero = 1'b0;
        exp_uf   = 1'b0;
        if (rst) begin
            arq.delete();
            exp_out = 0;
        end else begin
            if (hs) begin
                if (arq.size() == 0) begin
                    check("spurious_ar", 1, 0);
                end else begin
                    x = arq.pop_front();
                    check("araddr", araddr, x.a);
                    check("arlen", arlen, x.l);
                end
                arlog.push_back({araddr, arlen});
                hs_cyc.push_back(cyc);
            end
            if (pop) begin
                e = fq.pop_front();
                pops_n++;
                last_pop_cyc = cyc;
                split_entry(e);
            end
            if (rl) last_rl_cyc = cyc;
            if (hs && !rl) exp_out++;
            else if (rl && !hs) begin
                if (exp_out == 0) exp_uf = 1'b1;
                else exp_out--;
            end
        end
        busy_exp = (arq.size() > 0);
        @(posedge clk);
        #1;
        cyc++;
        check("outstanding", outstanding, exp_out);
        check("busy", busy, busy_exp);
        check("err_zero_len", err_zero_len, exp_zero);
        check("err_underflow", err_underflow, exp_uf);
        if (err_zero_len) zero_n++;
        @(negedge clk);
    endtask

    function automatic bit idle_now();
        return fq.size() == 0 && arq.size() == 0 && (r_mode == 0 || exp_out == 0);
    endfunction

    task automatic run_idle(input int max);
        int n = 0;
        while (!idle_now() && n < max) begin
            tick();
            n++;
        end
        if (!idle_now()) check("idle_timeout", 0, 1);
    endtask

    int base, p0, z0, n, rlc;
    logic [ADDR_W-1:0] ca;
    logic [7:0]        cl;

    initial begin
        rst_req = 1'b1; ar_fix = 1'b1; ar_rand = 1'b0; r_mode = 0; force_rl = 1'b0;
        rst = 1'b1; fifo_rd_vld = 1'b0; fifo_rd_data = '0;
        arready = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        @(negedge clk);

        // reset: an entry visible during reset must not be popped
        push_entry(5, 28'h0000010);
        tick(); tick();
        check("rst_arvalid", arvalid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_busy", busy, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_pops", pops_n, 0);
        check("arsize", arsize, 3'd5);
        check("arburst", arburst, 2'b01);
        fq.delete();
        rst_req = 1'b0;

        // 40 beats -> 16+16+8
        r_mode = 1; base = arlog.size(); p0 = pops_n;
        push_entry(40, 28'h0001000);
        run_idle(500);
        check("t1_pops", pops_n - p0, 1);
        check("t1_ars", arlog.size() - base, 3);
        if (arlog.size() - base == 3) begin
            check("t1_ar0", arlog[base],     {28'h0001000, 8'd15});
            check("t1_ar1", arlog[base + 1], {28'h0001200, 8'd15});
            check("t1_ar2", arlog[base + 2], {28'h0001400, 8'd7});
            check("t1_latency", hs_cyc[base] - last_pop_cyc, 2);
        end

        // credit limit: 4 bursts then stall, one rlast releases the 5th
        r_mode = 0; base = arlog.size();
        push_entry(100, 28'h0002000);
        repeat (20) tick();
        check("t2_ars_stalled", arlog.size() - base, 4);
        check("t2_arvalid", arvalid, 0);
        check("t2_outstanding", outstanding, 4);
        force_rl = 1'b1; tick(); force_rl = 1'b0;
        rlc = last_rl_cyc; n = 0;
        while (arlog.size() - base < 5 && n < 5) begin tick(); n++; end
        check("t2_fifth", arlog.size() - base, 5);
        if (arlog.size() - base == 5) check("t2_fifth_latency", (hs_cyc[base + 4] - rlc) <= 2, 1);
        check("t2_outstanding_after", outstanding, 4);
        r_mode = 1;
        run_idle(500);

        // zero-length entry dropped, next entry handled
        base = arlog.size(); p0 = pops_n; z0 = zero_n;
        push_entry(0, 28'h0000040);
        push_entry(1, 28'h0000020);
        run_idle(500);
        check("t3_pops", pops_n - p0, 2);
        check("t3_zero_pulses", zero_n - z0, 1);
        check("t3_ars", arlog.size() - base, 1);
        if (arlog.size() - base == 1) check("t3_ar0", arlog[base], {28'h0000020, 8'd0});

        // address wrap
        base = arlog.size();
        push_entry(20, 28'hFFFFF00);
        run_idle(500);
        check("t4_ars", arlog.size() - base, 2);
        if (arlog.size() - base == 2) begin
            check("t4_ar0", arlog[base],     {28'hFFFFF00, 8'd15});
            check("t4_ar1", arlog[base + 1], {28'h0000100, 8'd3});
        end

        // arready low for 5 cycles: command held
        r_mode = 0; ar_fix = 1'b0;
        push_entry(16, 28'h0003000);
        n = 0;
        while (!arvalid && n < 10) begin tick(); n++; end
        check("t5_arvalid_up", arvalid, 1);
        ca = araddr; cl = arlen;
        repeat (5) begin
            tick();
            check("t5_hold_vld", arvalid, 1);
            check("t5_hold_addr", araddr, ca);
            check("t5_hold_len", arlen, cl);
        end
        ar_fix = 1'b1;
        r_mode = 1;
        run_idle(500);

        // AR handshake and rlast together at outstanding=2
        r_mode = 0; base = arlog.size();
        push_entry(64, 28'h0006000);
        n = 0;
        while (arlog.size() - base < 2 && n < 20) begin tick(); n++; end
        ar_fix = 1'b0; n = 0;
        while (!arvalid && n < 10) begin tick(); n++; end
        check("t5_out2", outstanding, 2);
        ar_fix = 1'b1; force_rl = 1'b1; tick(); force_rl = 1'b0;
        check("t5_simul_out", outstanding, 2);
        check("t5_simul_ars", arlog.size() - base, 3);
        r_mode = 1;
        run_idle(500);

        // rlast with nothing outstanding
        r_mode = 0;
        force_rl = 1'b1; tick(); force_rl = 1'b0;
        check("t5_underflow", err_underflow, 1);
        check("t5_underflow_out", outstanding, 0);

        // reset while issuing with beats remaining
        r_mode = 1; ar_fix = 1'b1; base = arlog.size();
        push_entry(100, 28'h0004000);
        n = 0;
        while (arlog.size() - base < 2 && n < 40) begin tick(); n++; end
        n = 0;
        while (!arvalid && n < 10) begin tick(); n++; end
        check("t6_in_issue", arvalid, 1);
        rst_req = 1'b1; tick(); rst_req = 1'b0;
        check("t6_arvalid", arvalid, 0);
        check("t6_outstanding", outstanding, 0);
        check("t6_busy", busy, 0);
        base = arlog.size();
        push_entry(8, 28'h0005000);
        run_idle(500);
        check("t6_ars", arlog.size() - base, 1);
        if (arlog.size() - base == 1) check("t6_ar0", arlog[base], {28'h0005000, 8'd7});

        // randomized traffic
        ar_rand = 1'b1; r_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) push_entry($urandom_range(0, 3), 28'($urandom));
            else push_entry($urandom_range(1, 80), 28'($urandom));
            repeat ($urandom_range(0, 6)) tick();
        end
        run_idle(20000);
        r_mode = 1;
        run_idle(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
